// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined bidirectional barrel shifter.
//   shift_dir_t : shift direction encoding (left / right)
//   shift_fill  : bit shifted into vacated positions for a given item
package shift_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_t;

  // Only arithmetic right shifts of negative operands fill with ones.
  function automatic logic shift_fill(shift_dir_t dir, logic arith, logic sign);
    return (dir == SHIFT_RIGHT) && arith && sign;
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage of the barrel shifter: conditionally shifts the incoming
// item by 2**K (when amount bit K is set) and registers it with a valid bit.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready_c upstream handshake (ready is combinational)
//   in_data .. in_sign    upstream item payload
//   out_ready             downstream ready
//   out_valid .. out_sign registered item payload towards the next stage
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned S_W = 3,
  parameter int unsigned K   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready_c,
  input  logic [N-1:0]     in_data,
  input  logic [S_W-1:0]   in_amount,
  input  shift_dir_t       in_dir,
  input  logic             in_arith,
  input  logic             in_sign,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  output logic [S_W-1:0]   out_amount,
  output shift_dir_t       out_dir,
  output logic             out_arith,
  output logic             out_sign
);

  localparam int unsigned SH = 2 ** K;

  typedef struct packed {
    logic [N-1:0]   data;
    logic [S_W-1:0] amount;
    shift_dir_t     dir;
    logic           arith;
    logic           sign;
  } stage_t;

  stage_t     pay_q, pay_d;
  logic       valid_q, valid_d;
  logic       fill_c;
  logic [N-1:0] shifted_c;

  // Next-state: accept when empty or when the downstream is draining us.
  always_comb begin
    valid_d    = valid_q;
    pay_d      = pay_q;
    in_ready_c = !valid_q || out_ready;
    fill_c     = shift_fill(in_dir, in_arith, in_sign);
    if (in_dir == SHIFT_LEFT) begin
      shifted_c = in_data << SH;
    end else begin
      shifted_c = (in_data >> SH) | (fill_c ? ~({N{1'b1}} >> SH) : '0);
    end
    if (in_ready_c) begin
      valid_d = in_valid;
      if (in_valid) begin
        pay_d.data   = in_amount[K] ? shifted_c : in_data;
        pay_d.amount = in_amount;
        pay_d.dir    = in_dir;
        pay_d.arith  = in_arith;
        pay_d.sign   = in_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q   <= pay_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = pay_q.data;
  assign out_amount = pay_q.amount;
  assign out_dir    = pay_q.dir;
  assign out_arith  = pay_q.arith;
  assign out_sign   = pay_q.sign;

endmodule

// File: rtl/pipelined_barrel_shifter_bidir.sv
// Variable-amount left/right barrel shifter, log2-pipelined on valid/ready
// streams. Stage k shifts by 2**k when amount bit k is set.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   up_valid/up_ready              operand handshake (up_ready combinational)
//   up_data, up_amount             operand and shift amount
//   up_dir, up_arith               0=left/1=right, arithmetic right fill
//   down_valid/down_ready          result handshake
//   down_data                      result (registered in the last stage)
module pipelined_barrel_shifter_bidir
  import shift_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned S_W = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           up_valid,
  output logic           up_ready,
  input  logic [N-1:0]   up_data,
  input  logic [S_W-1:0] up_amount,
  input  logic           up_dir,
  input  logic           up_arith,
  output logic           down_valid,
  input  logic           down_ready,
  output logic [N-1:0]   down_data
);

  // Index k is the input of stage k; index S_W is the pipeline output.
  logic [S_W:0]   v;
  logic [S_W:0]   rdy;
  logic [S_W:0]   ari;
  logic [S_W:0]   sgn;
  logic [N-1:0]   dat   [S_W+1];
  logic [S_W-1:0] amt   [S_W+1];
  shift_dir_t     dir_s [S_W+1];
  logic           tail_unused;

  assign v[0]     = up_valid;
  assign dat[0]   = up_data;
  assign amt[0]   = up_amount;
  assign dir_s[0] = shift_dir_t'(up_dir);
  assign ari[0]   = up_arith;
  // Sign captured at entry so arithmetic fill survives earlier stages.
  assign sgn[0]   = up_data[N-1];
  assign rdy[S_W] = down_ready;

  for (genvar k = 0; k < S_W; k++) begin : g_stage
    shift_pipe_stage #(.N(N), .S_W(S_W), .K(k)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (v[k]),
      .in_ready_c (rdy[k]),
      .in_data    (dat[k]),
      .in_amount  (amt[k]),
      .in_dir     (dir_s[k]),
      .in_arith   (ari[k]),
      .in_sign    (sgn[k]),
      .out_ready  (rdy[k+1]),
      .out_valid  (v[k+1]),
      .out_data   (dat[k+1]),
      .out_amount (amt[k+1]),
      .out_dir    (dir_s[k+1]),
      .out_arith  (ari[k+1]),
      .out_sign   (sgn[k+1])
    );
  end

  assign up_ready   = rdy[0];
  assign down_valid = v[S_W];
  assign down_data  = dat[S_W];

  // Control fields leaving the last stage have no consumer.
  assign tail_unused = ^{amt[S_W], dir_s[S_W], ari[S_W], sgn[S_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter_bidir.sv
// Self-checking bench for pipelined_barrel_shifter_bidir (N=8 and N=5 instances).
module tb_pipelined_barrel_shifter_bidir;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // N=8 instance
  logic       up_valid, up_ready, up_dir, up_arith, down_valid, down_ready;
  logic [7:0] up_data, down_data;
  logic [2:0] up_amount;

  // N=5 instance
  logic       f_up_valid, f_up_ready, f_up_dir, f_up_arith, f_down_valid, f_down_ready;
  logic [4:0] f_up_data, f_down_data;
  logic [2:0] f_up_amount;

  pipelined_barrel_shifter_bidir #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .up_amount(up_amount), .up_dir(up_dir), .up_arith(up_arith),
    .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data)
  );

  pipelined_barrel_shifter_bidir #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(f_up_valid), .up_ready(f_up_ready), .up_data(f_up_data),
    .up_amount(f_up_amount), .up_dir(f_up_dir), .up_arith(f_up_arith),
    .down_valid(f_down_valid), .down_ready(f_down_ready), .down_data(f_down_data)
  );

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;
  logic last_acc = 1'b0;
  logic [31:0] exp_q[$];

  // Reference: plain shift operators on a w-bit value.
  function automatic logic [31:0] ref_shift(int w, logic [31:0] d, int a, logic dir, logic ar);
    logic [31:0] m;
    m = 32'((64'(1) << w) - 64'(1));
    d = d & m;
    if (!dir) return (d << a) & m;
    if (ar && d[w-1]) return 32'($signed(d | ~m) >>> a) & m;
    return d >> a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic rand8();
    up_data   = 8'($urandom);
    up_amount = 3'($urandom_range(0, 7));
    up_dir    = 1'($urandom);
    up_arith  = 1'($urandom);
  endtask

  // One clock of the N=8 stream: score outputs, record accepted inputs.
  task automatic cycle8();
    logic acc;
    @(negedge clk);
    acc = up_valid && up_ready;
    if (down_valid && down_ready) begin
      n_out++;
      check("result_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("stream_data", 32'(down_data), exp_q.pop_front());
    end
    if (acc) begin
      n_acc++;
      exp_q.push_back(ref_shift(8, 32'(up_data), int'(up_amount), up_dir, up_arith));
    end
    last_acc = acc;
    @(posedge clk); #1;
  endtask

  // Single isolated op on an empty N=8 pipeline with latency and pulse checks.
  task automatic op8(input string tag, input logic [7:0] d, input logic [2:0] a,
                     input logic dir, input logic ar, input logic [7:0] expv);
    int lat;
    up_data = d; up_amount = a; up_dir = dir; up_arith = ar;
    up_valid = 1'b1; down_ready = 1'b1;
    #1;
    check({tag, "_upready"}, 32'(up_ready), 32'd1);
    @(posedge clk); #1;
    up_valid = 1'b0;
    lat = 0;
    while (!down_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check(tag, 32'(down_data), 32'(expv));
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(down_valid), 32'd0);
  endtask

  task automatic op5(input string tag, input logic [4:0] d, input logic [2:0] a,
                     input logic dir, input logic ar, input logic [4:0] expv);
    int lat;
    f_up_data = d; f_up_amount = a; f_up_dir = dir; f_up_arith = ar;
    f_up_valid = 1'b1; f_down_ready = 1'b1;
    @(posedge clk); #1;
    f_up_valid = 1'b0;
    lat = 0;
    while (!f_down_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check(tag, 32'(f_down_data), 32'(expv));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held;
    logic [4:0] d5;
    logic [2:0] a5;
    logic       dr5, ar5;

    rst_n = 1'b0;
    up_valid = 1'b0; up_data = '0; up_amount = '0; up_dir = 1'b0; up_arith = 1'b0; down_ready = 1'b0;
    f_up_valid = 1'b0; f_up_data = '0; f_up_amount = '0; f_up_dir = 1'b0; f_up_arith = 1'b0; f_down_ready = 1'b0;
    #1;
    check("rst_down_valid", 32'(down_valid), 32'd0);
    check("rst_down_data", 32'(down_data), 32'd0);
    check("rst_up_ready", 32'(up_ready), 32'd1);
    check("rst_down_valid5", 32'(f_down_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    op8("left3",      8'b1011_0001, 3'd3, 1'b0, 1'b0, 8'b1000_1000);
    op8("rlog3",      8'b1011_0001, 3'd3, 1'b1, 1'b0, 8'b0001_0110);
    op8("rari3_neg",  8'b1011_0001, 3'd3, 1'b1, 1'b1, 8'b1111_0110);
    op8("rari3_pos",  8'b0011_0001, 3'd3, 1'b1, 1'b1, 8'b0000_0110);
    op8("amt0_left",  8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5);
    op8("amt0_right", 8'hA5, 3'd0, 1'b1, 1'b1, 8'hA5);
    op8("left7",      8'hFF, 3'd7, 1'b0, 1'b0, 8'h80);
    op8("rari7",      8'h80, 3'd7, 1'b1, 1'b1, 8'hFF);

    // Back-to-back random, full throughput
    n_acc = 0; n_out = 0;
    down_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rand8();
      up_valid = 1'b1;
      cycle8();
    end
    up_valid = 1'b0;
    repeat (3) cycle8();
    check("bb_accepts", 32'(n_acc), 32'd200);
    check("bb_results", 32'(n_out), 32'd200);
    check("bb_drained", 32'(exp_q.size()), 32'd0);

    // Stall: exactly three items held
    n_acc = 0; n_out = 0;
    down_ready = 1'b0;
    rand8();
    up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle8();
      if (last_acc) rand8();
    end
    check("stall_accepts", 32'(n_acc), 32'd3);
    check("stall_up_ready", 32'(up_ready), 32'd0);
    check("stall_down_valid", 32'(down_valid), 32'd1);
    held = down_data;
    repeat (2) cycle8();
    check("stall_hold_data", 32'(down_data), 32'(held));
    check("stall_hold_valid", 32'(down_valid), 32'd1);
    up_valid = 1'b0;
    down_ready = 1'b1;
    repeat (3) cycle8();
    check("release_results", 32'(n_out), 32'd3);

    // Random valid/ready toggling
    for (int i = 0; i < 300; i++) begin
      if (!up_valid || last_acc) begin
        rand8();
        up_valid = 1'($urandom);
      end
      down_ready = 1'($urandom);
      cycle8();
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    repeat (6) cycle8();
    check("toggle_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with items in flight
    down_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand8();
      up_valid = 1'b1;
      cycle8();
    end
    up_valid = 1'b0;
    cycle8();
    check("pre_reset_valid", 32'(down_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(down_valid), 32'd0);
    check("async_rst_data", 32'(down_data), 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_out = 0;
    down_ready = 1'b1;
    repeat (5) cycle8();
    check("no_stale", 32'(n_out), 32'd0);
    op8("post_reset", 8'b1011_0001, 3'd3, 1'b0, 1'b0, 8'b1000_1000);

    // N=5: amounts beyond the width
    op5("n5_rari6", 5'b10010, 3'd6, 1'b1, 1'b1, 5'b11111);
    op5("n5_left5", 5'b10010, 3'd5, 1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 20; i++) begin
      d5 = 5'($urandom); a5 = 3'($urandom_range(0, 7));
      dr5 = 1'($urandom); ar5 = 1'($urandom);
      op5("n5_rand", d5, a5, dr5, ar5, 5'(ref_shift(5, 32'(d5), int'(a5), dr5, ar5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
